// File: rtl/me_mem_loader.sv
// Front-end loader for the motion estimator: buffers one reference block and one search
// window from a byte stream, serves the core's read ports and hands the result downstream.
module me_mem_loader #(
   parameter int unsigned R_DEPTH = 256,
   parameter int unsigned S_DEPTH = 1024,
   parameter int unsigned DW      = 8
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   output logic          in_ready,
   input  logic [DW-1:0] in_data,
   input  logic          in_last,
   output logic          start,
   input  logic [7:0]    AddressR,
   input  logic [9:0]    AddressS1,
   input  logic [9:0]    AddressS2,
   output logic [DW-1:0] R,
   output logic [DW-1:0] S1,
   output logic [DW-1:0] S2,
   input  logic          completed,
   input  logic [7:0]    BestDist,
   input  logic [3:0]    motionX,
   input  logic [3:0]    motionY,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [7:0]    out_dist,
   output logic [3:0]    out_mx,
   output logic [3:0]    out_my,
   output logic          err
);

   localparam int unsigned CW = $clog2(S_DEPTH);
   localparam logic [CW-1:0] RLast = CW'(R_DEPTH - 1);
   localparam logic [CW-1:0] SLast = CW'(S_DEPTH - 1);

   typedef enum logic [2:0] {StLoadR, StLoadS, StStart, StRun, StResult} state_e;

   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          in_ready_q, in_ready_d;
   logic          start_q, start_d;
   logic          out_valid_q, out_valid_d;
   logic [7:0]    out_dist_q, out_dist_d;
   logic [3:0]    out_mx_q, out_mx_d;
   logic [3:0]    out_my_q, out_my_d;
   logic          err_q, err_d;
   logic [DW-1:0] r_q, s1_q, s2_q;

   logic [DW-1:0] ram_r [R_DEPTH];
   logic [DW-1:0] ram_s [S_DEPTH];

   logic accept;
   logic we_r, we_s;

   assign accept = in_valid & in_ready_q;
   assign we_r   = accept & (state_q == StLoadR);
   assign we_s   = accept & (state_q == StLoadS);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      err_d       = err_q;
      out_valid_d = out_valid_q;
      out_dist_d  = out_dist_q;
      out_mx_d    = out_mx_q;
      out_my_d    = out_my_q;
      case (state_q)
         StLoadR: begin
            if (accept) begin
               if (in_last) begin
                  err_d = 1'b1;
                  cnt_d = '0;
               end else if (cnt_q == RLast) begin
                  cnt_d   = '0;
                  state_d = StLoadS;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StLoadS: begin
            if (accept) begin
               if (in_last && (cnt_q == SLast)) begin
                  cnt_d   = '0;
                  state_d = StStart;
               end else if (in_last || (cnt_q == SLast)) begin
                  // Misplaced or missing in_last: drop the frame and resync on the next one.
                  err_d   = 1'b1;
                  cnt_d   = '0;
                  state_d = StLoadR;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StStart: state_d = StRun;
         StRun: begin
            if (completed) begin
               out_dist_d  = BestDist;
               out_mx_d    = motionX;
               out_my_d    = motionY;
               out_valid_d = 1'b1;
               state_d     = StResult;
            end
         end
         StResult: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = StLoadR;
            end
         end
         default: begin
            cnt_d   = '0;
            state_d = StLoadR;
         end
      endcase
      start_d    = (state_d == StStart);
      in_ready_d = (state_d == StLoadR) || (state_d == StLoadS);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= StLoadR;
         cnt_q       <= '0;
         in_ready_q  <= 1'b0;
         start_q     <= 1'b0;
         out_valid_q <= 1'b0;
         out_dist_q  <= '0;
         out_mx_q    <= '0;
         out_my_q    <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         in_ready_q  <= in_ready_d;
         start_q     <= start_d;
         out_valid_q <= out_valid_d;
         out_dist_q  <= out_dist_d;
         out_mx_q    <= out_mx_d;
         out_my_q    <= out_my_d;
         err_q       <= err_d;
      end
   end

   // RAM arrays carry no reset; only the read data registers are cleared.
   always_ff @(posedge clk) begin
      if (we_r) ram_r[cnt_q[7:0]] <= in_data;
      if (we_s) ram_s[cnt_q] <= in_data;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_q  <= '0;
         s1_q <= '0;
         s2_q <= '0;
      end else begin
         r_q  <= ram_r[AddressR];
         s1_q <= ram_s[AddressS1];
         s2_q <= ram_s[AddressS2];
      end
   end

   assign in_ready  = in_ready_q;
   assign start     = start_q;
   assign out_valid = out_valid_q;
   assign out_dist  = out_dist_q;
   assign out_mx    = out_mx_q;
   assign out_my    = out_my_q;
   assign err       = err_q;
   assign R         = r_q;
   assign S1        = s1_q;
   assign S2        = s2_q;

endmodule

// File: tb/tb_me_mem_loader.sv
// Randomised bench for me_mem_loader against a frame-level model of the two RAMs.
module tb_me_mem_loader;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       in_valid, in_ready, in_last;
   logic [7:0] in_data;
   logic       start;
   logic [7:0] AddressR;
   logic [9:0] AddressS1, AddressS2;
   logic [7:0] R, S1, S2;
   logic       completed;
   logic [7:0] BestDist;
   logic [3:0] motionX, motionY;
   logic       out_valid, out_ready;
   logic [7:0] out_dist;
   logic [3:0] out_mx, out_my;
   logic       err;

   int n_chk = 0;
   int n_pass = 0;
   int start_seen = 0;
   logic [7:0] ref_r [256];
   logic [7:0] ref_s [1024];

   always #5 clk = ~clk;

   always @(posedge clk) if (start === 1'b1) start_seen++;

   me_mem_loader dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .start     (start),
      .AddressR  (AddressR),
      .AddressS1 (AddressS1),
      .AddressS2 (AddressS2),
      .R         (R),
      .S1        (S1),
      .S2        (S2),
      .completed (completed),
      .BestDist  (BestDist),
      .motionX   (motionX),
      .motionY   (motionY),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_dist  (out_dist),
      .out_mx    (out_mx),
      .out_my    (out_my),
      .err       (err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Called at a negedge; returns at the negedge after the byte has been accepted.
   task automatic send_byte(input logic [7:0] d, input logic last);
      int budget = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      while (in_ready !== 1'b1 && budget < 200) begin
         @(negedge clk);
         budget++;
      end
      if (in_ready !== 1'b1) check("in_ready_timeout", 32'(in_ready), 32'd1);
      @(negedge clk);
      if (!last && $urandom_range(0, 7) == 0) begin
         in_valid = 1'b0;
         @(negedge clk);
      end
   endtask

   // counting=1 gives R[i]=i, S[j]=j[7:0]; bad_idx>=0 raises in_last early; n_bytes truncates.
   task automatic send_frame(input bit counting, input int bad_idx, input bit omit_last,
                             input int n_bytes);
      bit   good;
      logic [7:0] d;
      logic last;
      good = (bad_idx < 0) && !omit_last && (n_bytes == 1280);
      for (int k = 0; k < n_bytes; k++) begin
         if (counting) d = (k < 256) ? 8'(k) : 8'(k - 256);
         else d = 8'($urandom);
         last = ((k == 1279) && !omit_last) || (k == bad_idx);
         if (good) begin
            if (k < 256) ref_r[k] = d;
            else ref_s[k-256] = d;
         end
         send_byte(d, last);
         if (k == bad_idx) break;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic read_check(input logic [7:0] ar, input logic [9:0] a1, input logic [9:0] a2);
      AddressR  = ar;
      AddressS1 = a1;
      AddressS2 = a2;
      @(negedge clk);
      check("rd_R", 32'(R), 32'(ref_r[ar]));
      check("rd_S1", 32'(S1), 32'(ref_s[a1]));
      check("rd_S2", 32'(S2), 32'(ref_s[a2]));
   endtask

   task automatic result_check(input logic [7:0] d, input logic [3:0] mx, input logic [3:0] my);
      completed = 1'b1;
      BestDist  = d;
      motionX   = mx;
      motionY   = my;
      @(negedge clk);
      completed = 1'b0;
      BestDist  = ~d;
      motionX   = ~mx;
      motionY   = ~my;
      for (int i = 0; i < 5; i++) begin
         check("res_valid", 32'(out_valid), 32'd1);
         check("res_dist", 32'(out_dist), 32'(d));
         check("res_mx", 32'(out_mx), 32'(mx));
         check("res_my", 32'(out_my), 32'(my));
         check("res_in_ready", 32'(in_ready), 32'd0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("res_taken_valid", 32'(out_valid), 32'd0);
      check("res_taken_in_ready", 32'(in_ready), 32'd1);
   endtask

   task automatic expect_start();
      check("start_pulse", 32'(start), 32'd1);
      check("start_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("start_one_cycle", 32'(start), 32'd0);
      check("run_in_ready", 32'(in_ready), 32'd0);
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      AddressR = '0; AddressS1 = '0; AddressS2 = '0;
      completed = 1'b0; BestDist = '0; motionX = '0; motionY = '0; out_ready = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_start", 32'(start), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_err", 32'(err), 32'd0);
      check("rst_out_dist", 32'({out_dist, out_mx, out_my}), 32'd0);
      check("rst_rdata", 32'({R, S1, S2}), 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Counting-pattern frame, fixed-address reads and a held result.
      send_frame(1'b1, -1, 1'b0, 1280);
      expect_start();
      read_check(8'h37, 10'h3FF, 10'h3FF);
      check("rd_R_const", 32'(R), 32'h37);
      check("rd_S_const", 32'({S1, S2}), 32'hFFFF);
      for (int i = 0; i < 4; i++)
         read_check(8'($urandom), 10'($urandom), 10'($urandom));
      result_check(8'h2A, 4'h3, 4'hC);

      // Early in_last, then a clean random frame.
      send_frame(1'b0, 500, 1'b0, 1280);
      check("early_last_err", 32'(err), 32'd1);
      check("early_last_in_ready", 32'(in_ready), 32'd1);
      check("early_last_no_start", 32'(start), 32'd0);
      send_frame(1'b0, -1, 1'b0, 1280);
      expect_start();
      check("err_sticky", 32'(err), 32'd1);
      for (int i = 0; i < 6; i++)
         read_check(8'($urandom), 10'($urandom), 10'($urandom));
      result_check(8'($urandom), 4'($urandom), 4'($urandom));

      // Reset in the middle of a frame.
      send_frame(1'b0, -1, 1'b0, 700);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("midrst_err", 32'(err), 32'd0);
      check("midrst_start", 32'(start), 32'd0);
      check("midrst_out_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      check("midrst_in_ready", 32'(in_ready), 32'd1);

      // Missing in_last on the final byte, stray completed, then a clean frame.
      send_frame(1'b0, -1, 1'b1, 1280);
      check("no_last_err", 32'(err), 32'd1);
      check("no_last_no_start", 32'(start), 32'd0);
      check("no_last_in_ready", 32'(in_ready), 32'd1);
      completed = 1'b1;
      BestDist  = 8'h55;
      @(negedge clk);
      completed = 1'b0;
      @(negedge clk);
      check("stray_completed", 32'(out_valid), 32'd0);
      send_frame(1'b0, -1, 1'b0, 1280);
      expect_start();
      for (int i = 0; i < 6; i++)
         read_check(8'($urandom), 10'($urandom), 10'($urandom));
      result_check(8'($urandom), 4'($urandom), 4'($urandom));

      check("start_count", 32'(start_seen), 32'd3);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
